serial_twos_comp_p: RTL and testbench

Parametrised serial complementer for LSB-first word streams, successor to the single-bit 2's-complement FSM. Accepts DIGIT_W bits per cycle and frames of WORD_DIGITS digits, so one word is WORD_DIGITS*DIGIT_W bits. Each word is passed, two's-complemented or ones'-complemented as selected per word. Reports zero, overflow and framing-error status per word. Sits between the serial shift-in front end and downstream serial arithmetic.

---
 rtl/serial_twos_comp_p_if.sv | 26 ++
 rtl/serial_twos_comp_p.sv | 121 ++++++++++++
 tb/tb_serial_twos_comp_p.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_twos_comp_p_if.sv
// Bundle of signals for the serial complementer: input digit stream toward the block, result stream and status back.
// master drives the input side; slave is the complementer itself.
interface serial_twos_comp_p_if #(
  parameter int DIGIT_W = 1
);
  logic               in_valid;
  logic               in_first;
  logic [DIGIT_W-1:0] in_digit;
  logic [1:0]         mode;
  logic               out_valid;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               zero;
  logic               ovf;
  logic               frame_err;

  modport master (
    output in_valid, in_first, in_digit, mode,
    input  out_valid, out_digit, out_last, zero, ovf, frame_err
  );

  modport slave (
    input  in_valid, in_first, in_digit, mode,
    output out_valid, out_digit, out_last, zero, ovf, frame_err
  );
endinterface

// File: rtl/serial_twos_comp_p.sv
// LSB-first serial pass / ones' complement / two's-complement negate, DIGIT_W bits per beat, WORD_DIGITS beats per word.
// Latency: one cycle, all outputs registered. No backpressure: every accepted beat yields exactly one output beat.
// SERIAL_COMP_STATUS_EN: when defined, zero/ovf/frame_err are computed; when undefined they are tied to 0.
module serial_twos_comp_p #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_twos_comp_p_if.slave bus
);
  localparam int              CNT_W    = $clog2(WORD_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cur_cnt;
  logic [1:0]         mode_q, cur_mode;
  logic               carry_q, carry_d, cur_carry;
  logic               accept, first_beat, is_last;
  logic [DIGIT_W:0]   sum;
  logic [DIGIT_W-1:0] res;
  logic               out_valid_q, out_last_q;
  logic [DIGIT_W-1:0] out_digit_q;

  // State register for the idle/in-word tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus per-digit arithmetic; an in_first beat overrides the
  // latched settings so the new word's first digit uses them immediately.
  always_comb begin
    state_d    = state_q;
    first_beat = bus.in_valid && bus.in_first;
    accept     = bus.in_valid && (bus.in_first || state_q == ACTIVE);
    cur_mode   = first_beat ? bus.mode : mode_q;
    cur_carry  = first_beat ? (bus.mode == 2'b01) : carry_q;
    cur_cnt    = first_beat ? '0 : cnt_q;
    is_last    = (cur_cnt == LAST_CNT);
    sum        = {1'b0, ~bus.in_digit} + {{DIGIT_W{1'b0}}, cur_carry};
    res        = bus.in_digit;
    carry_d    = cur_carry;
    case (cur_mode)
      2'b01: begin
        res     = sum[DIGIT_W-1:0];
        carry_d = sum[DIGIT_W];
      end
      2'b10:   res = ~bus.in_digit;
      default: res = bus.in_digit;
    endcase
    cnt_d = is_last ? '0 : cur_cnt + 1'b1;
    if (accept) state_d = is_last ? IDLE : ACTIVE;
  end

  // Word-context registers and the registered result stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_digit_q <= '0;
    end else begin
      out_valid_q <= accept;
      out_last_q  <= accept && is_last;
      if (accept) begin
        cnt_q       <= cnt_d;
        mode_q      <= cur_mode;
        carry_q     <= carry_d;
        out_digit_q <= res;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_digit = out_digit_q;

`ifdef SERIAL_COMP_STATUS_EN
  localparam logic [DIGIT_W-1:0] MSB_ONLY = DIGIT_W'(1) << (DIGIT_W - 1);

  logic all_zero_q, zero_acc, ovf_hit, frame_bad;
  logic zero_q, ovf_q, frame_err_q;

  // Running all-zero result, most-negative detection and framing check.
  always_comb begin
    zero_acc  = (first_beat ? 1'b1 : all_zero_q) && (res == '0);
    ovf_hit   = (cur_mode == 2'b01) && is_last && cur_carry && (bus.in_digit == MSB_ONLY);
    frame_bad = bus.in_valid && (bus.in_first == (state_q == ACTIVE));
  end

  // Status registers; zero/ovf hold between accepted beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      all_zero_q  <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      if (accept) begin
        all_zero_q <= zero_acc;
        zero_q     <= zero_acc;
        ovf_q      <= ovf_hit;
      end
    end
  end

  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.frame_err = frame_err_q;
`else
  assign bus.zero      = 1'b0;
  assign bus.ovf       = 1'b0;
  assign bus.frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_twos_comp_p.sv
// Bench for serial_twos_comp_p: three configurations (1x8, 4x2, 2x4 bits x digits) driven by directed words.
// An arithmetic word-level model predicts every output beat; literal word results pin the model.
module tb_serial_twos_comp_p;
`ifdef SERIAL_COMP_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       drv_v [3];
  logic       drv_f [3];
  logic [3:0] drv_d [3];
  logic [1:0] drv_m [3];
  logic       o_vld [3];
  logic       o_last[3];
  logic       o_zero[3];
  logic       o_ovf [3];
  logic       o_fe  [3];
  logic [3:0] o_dig [3];

  serial_twos_comp_p_if #(.DIGIT_W(1)) bus0 ();
  serial_twos_comp_p_if #(.DIGIT_W(4)) bus1 ();
  serial_twos_comp_p_if #(.DIGIT_W(2)) bus2 ();

  serial_twos_comp_p #(.DIGIT_W(1), .WORD_DIGITS(8)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  serial_twos_comp_p #(.DIGIT_W(4), .WORD_DIGITS(2)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  serial_twos_comp_p #(.DIGIT_W(2), .WORD_DIGITS(4)) u2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus0.in_valid = drv_v[0];  assign bus0.in_first = drv_f[0];
  assign bus0.in_digit = drv_d[0][0:0]; assign bus0.mode = drv_m[0];
  assign bus1.in_valid = drv_v[1];  assign bus1.in_first = drv_f[1];
  assign bus1.in_digit = drv_d[1];  assign bus1.mode = drv_m[1];
  assign bus2.in_valid = drv_v[2];  assign bus2.in_first = drv_f[2];
  assign bus2.in_digit = drv_d[2][1:0]; assign bus2.mode = drv_m[2];

  assign o_vld[0] = bus0.out_valid; assign o_last[0] = bus0.out_last; assign o_dig[0] = {3'b000, bus0.out_digit};
  assign o_zero[0] = bus0.zero; assign o_ovf[0] = bus0.ovf; assign o_fe[0] = bus0.frame_err;
  assign o_vld[1] = bus1.out_valid; assign o_last[1] = bus1.out_last; assign o_dig[1] = bus1.out_digit;
  assign o_zero[1] = bus1.zero; assign o_ovf[1] = bus1.ovf; assign o_fe[1] = bus1.frame_err;
  assign o_vld[2] = bus2.out_valid; assign o_last[2] = bus2.out_last; assign o_dig[2] = {2'b00, bus2.out_digit};
  assign o_zero[2] = bus2.zero; assign o_ovf[2] = bus2.ovf; assign o_fe[2] = bus2.frame_err;

  int dw[3] = '{1, 4, 2};
  int wd[3] = '{8, 2, 4};

  // model state and expectations
  bit         m_active[3];
  int         m_cnt[3];
  logic [1:0] m_mode[3];
  longint     m_w[3];
  bit         m_start[3];
  bit         rst_seen[3];
  bit         e_vld[3], e_last[3], e_zero[3], e_ovf[3], e_fe[3];
  logic [3:0] e_dig[3];
  // observed DUT words
  longint     a_word[3], last_word[3];
  int         a_pos[3], n_last[3], n_fe[3];
  bit         last_zero[3], last_ovf[3];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  task automatic model_reset(int i);
    m_active[i] = 0; m_cnt[i] = 0; m_mode[i] = 2'b00; m_w[i] = 0; m_start[i] = 0;
    rst_seen[i] = 1;
    e_vld[i] = 0; e_last[i] = 0; e_zero[i] = 0; e_ovf[i] = 0; e_fe[i] = 0; e_dig[i] = 4'h0;
    a_word[i] = 0; a_pos[i] = 0;
  endtask

  // Word-level model: the result so far is f(W_low) reduced mod 2^(bits seen),
  // and the newest digit is read straight out of that value.
  task automatic model_step(int i);
    longint mask, res;
    int     nb;
    bit     acc;
    rst_seen[i] = 0;
    acc        = drv_v[i] && (drv_f[i] || m_active[i]);
    e_fe[i]    = STAT && drv_v[i] && (drv_f[i] == m_active[i]);
    e_vld[i]   = acc;
    e_last[i]  = 0;
    m_start[i] = acc && drv_f[i];
    if (acc) begin
      if (drv_f[i]) begin
        m_active[i] = 1; m_cnt[i] = 0; m_mode[i] = drv_m[i]; m_w[i] = 0;
      end
      m_w[i] |= (longint'(drv_d[i]) & ((longint'(1) << dw[i]) - 1)) << (m_cnt[i] * dw[i]);
      nb   = (m_cnt[i] + 1) * dw[i];
      mask = (longint'(1) << nb) - 1;
      case (m_mode[i])
        2'b01:   res = (-m_w[i]) & mask;
        2'b10:   res = (~m_w[i]) & mask;
        default: res = m_w[i];
      endcase
      e_dig[i] = 4'(res >> (m_cnt[i] * dw[i]));
      if (m_cnt[i] == wd[i] - 1) begin
        e_last[i]   = 1;
        e_zero[i]   = STAT && (res == 0);
        e_ovf[i]    = STAT && (m_mode[i] == 2'b01) && (m_w[i] == (longint'(1) << (nb - 1)));
        m_active[i] = 0;
        m_cnt[i]    = 0;
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  task automatic compare(int i);
    chk("out_valid", i, o_vld[i], e_vld[i]);
    chk("out_last", i, o_last[i], e_last[i]);
    chk("frame_err", i, o_fe[i], e_fe[i]);
    if (e_vld[i] || rst_seen[i]) chk("out_digit", i, o_dig[i], e_dig[i]);
    if (e_last[i] || rst_seen[i]) begin
      chk("zero", i, o_zero[i], e_zero[i]);
      chk("ovf", i, o_ovf[i], e_ovf[i]);
    end
    if (o_fe[i]) n_fe[i]++;
    if (o_vld[i]) begin
      if (m_start[i]) begin a_word[i] = 0; a_pos[i] = 0; end
      a_word[i] |= longint'(o_dig[i]) << (a_pos[i] * dw[i]);
      a_pos[i]++;
      if (o_last[i]) begin
        last_word[i] = a_word[i]; last_zero[i] = o_zero[i]; last_ovf[i] = o_ovf[i];
        n_last[i]++;
      end
    end
  endtask

  // model update at the edge, DUT check shortly after
  initial begin
    for (int i = 0; i < 3; i++) begin model_reset(i); n_last[i] = 0; n_fe[i] = 0; last_word[i] = 0; end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) if (!reset) model_reset(i); else model_step(i);
      #1;
      for (int i = 0; i < 3; i++) compare(i);
    end
  end

  task automatic clear_drv();
    for (int k = 0; k < 3; k++) begin drv_v[k] = 0; drv_f[k] = 0; drv_d[k] = 4'h0; drv_m[k] = 2'b00; end
  endtask

  task automatic beat(int i, bit v, bit f, logic [3:0] d, logic [1:0] m);
    @(negedge clk);
    clear_drv();
    drv_v[i] = v; drv_f[i] = f; drv_d[i] = d; drv_m[i] = m;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(negedge clk); clear_drv(); end
  endtask

  // mode is deliberately scrambled on non-first beats; only the first beat's mode counts
  task automatic send_word(int i, logic [1:0] m, int w, int stall_at, int stall_n);
    for (int k = 0; k < wd[i]; k++) begin
      if (k == stall_at) idle(stall_n);
      beat(i, 1'b1, k == 0, 4'((w >> (k * dw[i])) & ((1 << dw[i]) - 1)), (k == 0) ? m : ~m);
    end
  endtask

  task automatic word_lit(string name, int i, longint w, bit z, bit o);
    idle(2);
    chk({name, "_word"}, i, last_word[i], w);
    chk({name, "_zero"}, i, last_zero[i], z & STAT);
    chk({name, "_ovf"}, i, last_ovf[i], o & STAT);
  endtask

  task automatic run_word(string name, int i, logic [1:0] m, int w, int stall_at, int stall_n,
                          longint exp_w, bit z, bit o);
    int nl;
    nl = n_last[i];
    send_word(i, m, w, stall_at, stall_n);
    word_lit(name, i, exp_w, z, o);
    chk({name, "_nlast"}, i, n_last[i], nl + 1);
  endtask

  initial begin
    int nl, nf;
    clear_drv();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, o_vld[i], 0);
      chk("rst_out_digit", i, o_dig[i], 0);
      chk("rst_out_last", i, o_last[i], 0);
      chk("rst_zero", i, o_zero[i], 0);
      chk("rst_ovf", i, o_ovf[i], 0);
      chk("rst_frame_err", i, o_fe[i], 0);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle(1);

    run_word("neg14", 0, 2'b01, 'h14, -1, 0, 'hEC, 0, 0);
    run_word("most_neg", 1, 2'b01, 'h80, -1, 0, 'h80, 0, 1);
    run_word("zero_word", 1, 2'b01, 'h00, -1, 0, 'h00, 1, 0);
    run_word("pass_b5", 2, 2'b00, 'hB5, -1, 0, 'hB5, 0, 0);
    run_word("ones_b5", 2, 2'b10, 'hB5, -1, 0, 'h4A, 0, 0);
    run_word("neg_b5", 2, 2'b01, 'hB5, -1, 0, 'h4B, 0, 0);
    run_word("rsvd_b5", 2, 2'b11, 'hB5, -1, 0, 'hB5, 0, 0);
    run_word("stall_b5", 2, 2'b01, 'hB5, 2, 3, 'h4B, 0, 0);
    run_word("stall_ones", 2, 2'b10, 'hB5, 2, 3, 'h4A, 0, 0);
    run_word("pass_zero", 2, 2'b00, 'h00, -1, 0, 'h00, 1, 0);

    // back-to-back words, no bubble
    nl = n_last[1];
    send_word(1, 2'b01, 'h80, -1, 0);
    send_word(1, 2'b10, 'h0F, -1, 0);
    word_lit("b2b", 1, 'hF0, 0, 0);
    chk("b2b_nlast", 1, n_last[1], nl + 2);

    // in_first on the 3rd digit abandons the old word
    nl = n_last[2]; nf = n_fe[2];
    beat(2, 1'b1, 1'b1, 4'h2, 2'b01);
    beat(2, 1'b1, 1'b0, 4'h0, 2'b01);
    send_word(2, 2'b00, 'h0F, -1, 0);
    word_lit("abandon", 2, 'h0F, 0, 0);
    chk("abandon_nlast", 2, n_last[2], nl + 1);
    chk("abandon_fe", 2, n_fe[2], nf + int'(STAT));

    // stray beat while idle is dropped
    nf = n_fe[2]; nl = n_last[2];
    beat(2, 1'b1, 1'b0, 4'h3, 2'b00);
    idle(2);
    chk("idle_beat_fe", 2, n_fe[2], nf + int'(STAT));
    chk("idle_beat_nlast", 2, n_last[2], nl);

    // asynchronous reset after 5 of 8 digits (word 0x04 negated gives a 1 in digit 4)
    for (int k = 0; k < 5; k++) beat(0, 1'b1, k == 0, 4'((4 >> k) & 1), 2'b01);
    @(posedge clk);
    #3;
    clear_drv();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 0, o_vld[0], 0);
    chk("midrst_out_digit", 0, o_dig[0], 0);
    chk("midrst_out_last", 0, o_last[0], 0);
    chk("midrst_zero", 0, o_zero[0], 0);
    chk("midrst_ovf", 0, o_ovf[0], 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    beat(0, 1'b1, 1'b0, 4'h1, 2'b00);
    idle(1);
    run_word("post_rst", 0, 2'b01, 'h14, -1, 0, 'hEC, 0, 0);
    run_word("post_rst_neg", 1, 2'b01, 'h80, -1, 0, 'h80, 0, 1);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
